// File: rtl/reg_file_async_mem.sv
// Storage for the single-cycle MIPS core: 32x32 register file (2 async reads, 1 sync write,
// r0 hardwired to zero) plus a word-organised memory with async read and sync write.
module reg_file_async_mem #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned MEM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rf_write,
    input  logic [4:0]  rr1,
    input  logic [4:0]  rr2,
    input  logic [4:0]  wr,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data
);

    logic [31:0] regs [32];
    logic [31:0] mem  [MEM_WORDS];

    logic [MEM_AW-1:0] mem_index;
    logic              unused_addr_bits;

    // Register file: reset clears everything and wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_write && (wr != 5'd0)) begin
            regs[wr] <= wd;
        end
    end

    // r0 is forced at the read mux so it reads zero even before the first reset.
    assign rd1 = (rr1 == 5'd0) ? 32'h0 : regs[rr1];
    assign rd2 = (rr2 == 5'd0) ? 32'h0 : regs[rr2];

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign mem_index        = mem_address[MEM_AW+1:2];
    assign unused_addr_bits = ^{mem_address[31:MEM_AW+2], mem_address[1:0]};

    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[mem_index] <= mem_write_data;
        end
    end

    assign mem_read_data = mem[mem_index];

endmodule

// File: tb/tb_reg_file_async_mem.sv
// Directed, table-driven bench for reg_file_async_mem: register file write/read/reset behaviour
// and memory addressing, write gating and asynchronous read.
module tb_reg_file_async_mem;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned MEM_AW    = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        rf_write;
    logic [4:0]  rr1, rr2, wr;
    logic [31:0] wd, rd1, rd2;
    logic        mem_write;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    int checks   = 0;
    int failures = 0;

    reg_file_async_mem #(
        .MEM_WORDS(MEM_WORDS),
        .MEM_AW   (MEM_AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rf_write      (rf_write),
        .rr1           (rr1),
        .rr2           (rr2),
        .wr            (wr),
        .wd            (wd),
        .rd1           (rd1),
        .rd2           (rd2),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  rr;
        logic [31:0] exp;
    } rf_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } mem_vec_t;

    rf_vec_t  rf_vecs  [6];
    mem_vec_t mem_vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic mem_wr(input logic [31:0] addr, input logic [31:0] data);
        mem_write      = 1'b1;
        mem_address    = addr;
        mem_write_data = data;
        tick();
        mem_write = 1'b0;
    endtask

    task automatic sweep_regs_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i);
            rr2 = 5'(31 - i);
            #1;
            check({name, "_rd1"}, rd1, 32'h0);
            check({name, "_rd2"}, rd2, 32'h0);
        end
    endtask

    initial begin
        rf_vecs[0] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 32'h12345678};
        rf_vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h00000000};
        rf_vecs[2] = '{1'b0, 5'd7,  32'hAAAA5555, 5'd7,  32'h00000000};
        rf_vecs[3] = '{1'b1, 5'd7,  32'h0F0F0F0F, 5'd7,  32'h0F0F0F0F};
        rf_vecs[4] = '{1'b1, 5'd7,  32'h11111111, 5'd5,  32'hDEADBEEF};
        rf_vecs[5] = '{1'b1, 5'd3,  32'h00000007, 5'd3,  32'h00000007};

        mem_vecs[0] = '{32'h0000_0008, 32'hCAFEF00D};
        mem_vecs[1] = '{32'h0000_0009, 32'hCAFEF00D};
        mem_vecs[2] = '{32'h0000_000B, 32'hCAFEF00D};
        mem_vecs[3] = '{32'h0000_0008 + MEM_WORDS * 4, 32'hCAFEF00D};
        mem_vecs[4] = '{32'h0000_0010, 32'h11112222};
        mem_vecs[5] = '{32'h8000_0014, 32'h33334444};
        mem_vecs[6] = '{32'h0000_0020, 32'hABCD0123};

        reset = 1'b1; rf_write = 1'b0; rr1 = '0; rr2 = '0; wr = '0; wd = '0;
        mem_write = 1'b0; mem_address = '0; mem_write_data = '0;
        tick();
        reset = 1'b0;
        sweep_regs_zero("reset");

        // Same-cycle read shows the old value until the edge.
        rf_write = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF; rr1 = 5'd5;
        #1;
        check("rf_before_edge", rd1, 32'h0);
        tick();
        rf_write = 1'b0;
        check("rf_after_edge", rd1, 32'hDEADBEEF);

        foreach (rf_vecs[k]) begin
            rf_write = rf_vecs[k].we; wr = rf_vecs[k].wr; wd = rf_vecs[k].wd;
            tick();
            rf_write = 1'b0;
            rr1 = rf_vecs[k].rr; rr2 = rf_vecs[k].rr;
            #1;
            check($sformatf("rf_vec%0d_rd1", k), rd1, rf_vecs[k].exp);
            check($sformatf("rf_vec%0d_rd2", k), rd2, rf_vecs[k].exp);
        end

        rr1 = 5'd5; rr2 = 5'd31;
        #1;
        check("rf_dual_rd1", rd1, 32'hDEADBEEF);
        check("rf_dual_rd2", rd2, 32'h12345678);

        // Reset wins over a simultaneous write.
        reset = 1'b1; rf_write = 1'b1; wr = 5'd3; wd = 32'h7;
        tick();
        reset = 1'b0; rf_write = 1'b0;
        rr1 = 5'd3;
        #1;
        check("rst_prio_r3", rd1, 32'h0);
        sweep_regs_zero("rst_mid");

        mem_wr(32'h0000_0008, 32'hCAFEF00D);
        mem_wr(32'h0000_0010, 32'h11112222);
        mem_wr(32'h0000_0017, 32'h33334444);
        mem_wr(32'h0000_0020 + MEM_WORDS * 4, 32'hABCD0123);
        foreach (mem_vecs[k]) begin
            mem_address = mem_vecs[k].addr;
            #1;
            check($sformatf("mem_vec%0d", k), mem_read_data, mem_vecs[k].exp);
        end

        // Write enable low: data changes must not reach the array.
        mem_write = 1'b0; mem_address = 32'h8; mem_write_data = 32'h0BADBAD0;
        tick();
        check("mem_gated", mem_read_data, 32'hCAFEF00D);

        mem_write = 1'b1; mem_address = 32'h10; mem_write_data = 32'h55556666;
        #1;
        check("mem_before_edge", mem_read_data, 32'h11112222);
        tick();
        mem_write = 1'b0;
        check("mem_after_edge", mem_read_data, 32'h55556666);

        // Asynchronous read: address switch mid-cycle, no edge in between.
        @(negedge clk);
        mem_address = 32'h8;
        #1;
        check("mem_async_a", mem_read_data, 32'hCAFEF00D);
        mem_address = 32'h14;
        #1;
        check("mem_async_b", mem_read_data, 32'h33334444);

        // Reset isolation: memory survives, registers clear.
        rf_write = 1'b1; wr = 5'd9; wd = 32'h00001234;
        tick();
        rf_write = 1'b0;
        rr1 = 5'd9;
        #1;
        check("iso_r9_written", rd1, 32'h00001234);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("iso_r9_cleared", rd1, 32'h0);
        mem_address = 32'h8;
        #1;
        check("iso_mem8", mem_read_data, 32'hCAFEF00D);
        mem_address = 32'h20;
        #1;
        check("iso_mem20", mem_read_data, 32'hABCD0123);
        sweep_regs_zero("iso");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
